result_sweep_checker: RTL and testbench

//  Synthesizable, parametrised result-SRAM sweep checker for the systolic-array TPU.
//  On a rising edge of start (TOP_tpu end_), it reads NUM_ROWS result rows and the matching expected rows,

---
 rtl/result_sweep_checker_if.sv | 14 +
 rtl/result_sweep_checker.sv | 152 +++++++++++++++
 tb/tb_result_sweep_checker.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_sweep_checker_if.sv
// result_sweep_checker_if: shared read port to the result and expected row memories
//   master (checker): drives rd_en/rd_addr, receives result_data/exp_data
//   slave  (memory) : receives rd_en/rd_addr, returns both rows RD_LATENCY cycles later
interface result_sweep_checker_if #(
    parameter int AW = 10,
    parameter int DW = 24 * 64
);
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] result_data;
    logic [DW-1:0] exp_data;
    modport master(output rd_en, rd_addr, input result_data, exp_data);
    modport slave(input rd_en, rd_addr, output result_data, exp_data);
endinterface

// File: rtl/result_sweep_checker.sv
// result_sweep_checker: sweeps NUM_ROWS result rows against expected rows, exact or within a signed tolerance
//   clk, rstn        clock, async active-low reset
//   start, abort     sweep request (rising edge) and cancel
//   tol_mode, tol    0=exact / 1=|diff|<=tol, both latched at sweep start
//   mem              read port (rd_en, rd_addr out; result_data, exp_data in)
//   busy, done       sweep running, 1-cycle completion pulse
//   pass, err_count, first_err_valid, first_err_addr, lane_err_mask   sweep statistics
//   row_chk_valid, row_chk_err                                        per-row compare strobe
module result_sweep_checker #(
    parameter int ADDRESSSIZE    = 10,
    parameter int MATRIX_SIZE    = 64,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int NUM_ROWS       = 64,
    parameter int BASE_ADDR      = 0,
    parameter int RD_LATENCY     = 1,
    parameter int ERR_CNT_BW     = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      tol_mode,
    input  logic [PARTIAL_SUM_BW-1:0] tol,
    result_sweep_checker_if.master    mem,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [ERR_CNT_BW-1:0]     err_count,
    output logic                      first_err_valid,
    output logic [ADDRESSSIZE-1:0]    first_err_addr,
    output logic [MATRIX_SIZE-1:0]    lane_err_mask,
    output logic                      row_chk_valid,
    output logic                      row_chk_err
);
    localparam int W   = PARTIAL_SUM_BW;
    localparam int CW  = $clog2(NUM_ROWS + 1);
    localparam int DCW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state;
    logic                   start_q;
    logic                   mode_q;
    logic [W-1:0]           tol_q;
    logic [CW-1:0]          cnt;
    logic [DCW-1:0]         dcnt;
    logic [RD_LATENCY-1:0]  v_d;
    logic [ADDRESSSIZE-1:0] a_d [RD_LATENCY];
    logic [MATRIX_SIZE-1:0] lane_bad;
    logic                   kill;
    logic                   cmp;
    logic                   row_bad;

    // W+1-bit difference cannot overflow, so extremes like 0x7FFFFF vs 0x800000 never wrap to small values
    for (genvar k = 0; k < MATRIX_SIZE; k++) begin : g_lane
        logic [W-1:0]   r;
        logic [W-1:0]   e;
        logic signed [W:0] diff;
        logic [W:0]     mag;
        assign r           = mem.result_data[k*W +: W];
        assign e           = mem.exp_data[k*W +: W];
        assign diff        = $signed({r[W-1], r}) - $signed({e[W-1], e});
        assign mag         = diff < 0 ? -diff : diff;
        assign lane_bad[k] = mode_q ? mag > {1'b0, tol_q} : r != e;
    end

    assign kill    = abort && state != IDLE;
    assign cmp     = v_d[RD_LATENCY-1] && !kill;
    assign row_bad = |lane_bad;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            start_q         <= 1'b0;
            mode_q          <= 1'b0;
            tol_q           <= '0;
            cnt             <= '0;
            dcnt            <= '0;
            v_d             <= '0;
            for (int i = 0; i < RD_LATENCY; i++) a_d[i] <= '0;
            mem.rd_en       <= 1'b0;
            mem.rd_addr     <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            lane_err_mask   <= '0;
            row_chk_valid   <= 1'b0;
            row_chk_err     <= 1'b0;
        end else begin
            start_q <= start;
            // abort flushes the read-valid pipeline so in-flight rows are never compared
            v_d     <= kill ? '0 : (v_d << 1) | RD_LATENCY'(mem.rd_en);
            a_d[0]  <= mem.rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) a_d[i] <= a_d[i-1];
            row_chk_valid <= cmp;
            row_chk_err   <= cmp && row_bad;
            done          <= 1'b0;
            if (cmp && row_bad) begin
                err_count     <= err_count + ERR_CNT_BW'(err_count != '1);
                lane_err_mask <= lane_err_mask | lane_bad;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= a_d[RD_LATENCY-1];
                end
            end
            if (kill) begin
                state     <= IDLE;
                mem.rd_en <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !start_q) begin
                        state           <= ISSUE;
                        busy            <= 1'b1;
                        mem.rd_en       <= 1'b1;
                        mem.rd_addr     <= ADDRESSSIZE'(BASE_ADDR);
                        cnt             <= '0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_addr  <= '0;
                        lane_err_mask   <= '0;
                        pass            <= 1'b0;
                        mode_q          <= tol_mode;
                        tol_q           <= tol;
                    end
                    ISSUE: if (cnt == CW'(NUM_ROWS - 1)) begin
                        state     <= DRAIN;
                        mem.rd_en <= 1'b0;
                        dcnt      <= '0;
                    end else begin
                        cnt         <= cnt + 1'b1;
                        mem.rd_addr <= mem.rd_addr + 1'b1;
                    end
                    DRAIN: if (dcnt == DCW'(RD_LATENCY - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        done  <= 1'b1;
                        pass  <= err_count == '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_result_sweep_checker.sv
// tb_result_sweep_checker: randomized and directed sweeps of two checker configurations against a row-level model
module tb_result_sweep_checker;
    localparam int M  = 8;
    localparam int P  = 24;
    localparam int DW = M * P;
    localparam int AW = 10;

    logic         clk = 0;
    logic         rstn = 0;
    logic         start = 0;
    logic         abort = 0;
    logic         tol_mode = 0;
    logic [P-1:0] tol = '0;
    bit           sel = 0;

    result_sweep_checker_if #(.AW(AW), .DW(DW)) if0 ();
    result_sweep_checker_if #(.AW(AW), .DW(DW)) if1 ();

    logic          busy0, done0, pass0, fev0, rv0, re0;
    logic [15:0]   err0;
    logic [AW-1:0] fea0;
    logic [M-1:0]  mask0;
    logic          busy1, done1, pass1, fev1, rv1, re1;
    logic [3:0]    err1;
    logic [AW-1:0] fea1;
    logic [M-1:0]  mask1;

    result_sweep_checker #(.ADDRESSSIZE(AW), .MATRIX_SIZE(M), .PARTIAL_SUM_BW(P), .NUM_ROWS(64),
        .BASE_ADDR(0), .RD_LATENCY(1), .ERR_CNT_BW(16)) dut0 (
        .clk(clk), .rstn(rstn), .start(start & ~sel), .abort(abort & ~sel), .tol_mode(tol_mode),
        .tol(tol), .mem(if0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_valid(fev0), .first_err_addr(fea0), .lane_err_mask(mask0),
        .row_chk_valid(rv0), .row_chk_err(re0));

    result_sweep_checker #(.ADDRESSSIZE(AW), .MATRIX_SIZE(M), .PARTIAL_SUM_BW(P), .NUM_ROWS(20),
        .BASE_ADDR(1020), .RD_LATENCY(3), .ERR_CNT_BW(4)) dut1 (
        .clk(clk), .rstn(rstn), .start(start & sel), .abort(abort & sel), .tol_mode(tol_mode),
        .tol(tol), .mem(if1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_valid(fev1), .first_err_addr(fea1), .lane_err_mask(mask1),
        .row_chk_valid(rv1), .row_chk_err(re1));

    always #5 clk = ~clk;

    logic [DW-1:0] mem_r [1024];
    logic [DW-1:0] mem_e [1024];
    logic [DW-1:0] p_r [3];
    logic [DW-1:0] p_e [3];

    always @(posedge clk) begin
        if0.result_data <= mem_r[if0.rd_addr];
        if0.exp_data    <= mem_e[if0.rd_addr];
        p_r[0] <= mem_r[if1.rd_addr];
        p_e[0] <= mem_e[if1.rd_addr];
        p_r[1] <= p_r[0];
        p_e[1] <= p_e[0];
        p_r[2] <= p_r[1];
        p_e[2] <= p_e[1];
    end
    assign if1.result_data = p_r[2];
    assign if1.exp_data    = p_e[2];

    logic          d_rd_en, d_busy, d_done, d_pass, d_fev, d_rv, d_re;
    logic [AW-1:0] d_addr, d_fea;
    logic [15:0]   d_err;
    logic [M-1:0]  d_mask;
    always_comb begin
        d_rd_en = sel ? if1.rd_en : if0.rd_en;
        d_addr  = sel ? if1.rd_addr : if0.rd_addr;
        d_busy  = sel ? busy1 : busy0;
        d_done  = sel ? done1 : done0;
        d_pass  = sel ? pass1 : pass0;
        d_fev   = sel ? fev1 : fev0;
        d_fea   = sel ? fea1 : fea0;
        d_err   = sel ? 16'(err1) : err0;
        d_mask  = sel ? mask1 : mask0;
        d_rv    = sel ? rv1 : rv0;
        d_re    = sel ? re1 : re0;
    end

    int n_chk = 0;
    int n_fail = 0;
    int addr_q[$];
    int n_rows = 0;
    int n_rowerr = 0;
    int n_done = 0;

    always @(negedge clk) begin
        if (d_rd_en) addr_q.push_back(int'(d_addr));
        if (d_rv) begin
            n_rows++;
            n_rowerr += int'(d_re);
        end
        if (d_done) n_done++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_same();
        for (int a = 0; a < 1024; a++) begin
            for (int w = 0; w < DW / 32; w++) mem_e[a][w*32 +: 32] = $urandom;
            mem_r[a] = mem_e[a];
        end
    endtask

    task automatic model(input int n, input int base, input bit mode, input logic [P-1:0] t,
                         output int errs, output int first, output logic [M-1:0] mask);
        logic [P-1:0] x, y;
        longint d;
        bit bad;
        errs = 0;
        first = -1;
        mask = '0;
        for (int i = 0; i < n; i++) begin
            int a;
            a = (base + i) % 1024;
            bad = 0;
            for (int k = 0; k < M; k++) begin
                x = mem_r[a][k*P +: P];
                y = mem_e[a][k*P +: P];
                d = longint'($signed(x)) - longint'($signed(y));
                if (d < 0) d = -d;
                if (mode ? d > longint'(t) : d != 0) begin
                    bad = 1;
                    mask[k] = 1'b1;
                end
            end
            if (bad) begin
                errs++;
                if (first < 0) first = a;
            end
        end
    endtask

    task automatic run_sweep(input bit s, input bit mode, input logic [P-1:0] t, input bit hold);
        int n, base, lat, maxc, errs, first, a0, r0, re0_, d0, k, bad_addr;
        logic [M-1:0] mask;
        bit seen;
        n    = s ? 20 : 64;
        base = s ? 1020 : 0;
        lat  = s ? 3 : 1;
        maxc = s ? 15 : 65535;
        sel  = s;
        model(n, base, mode, t, errs, first, mask);
        @(negedge clk);
        a0 = addr_q.size();
        r0 = n_rows;
        re0_ = n_rowerr;
        d0 = n_done;
        tol_mode = mode;
        tol = t;
        start = 1;
        abort = 1'($urandom % 2);
        seen = 0;
        k = 0;
        while (!seen && k < 300) begin
            @(negedge clk);
            k++;
            abort = 0;
            if (!hold) start = 0;
            if (k == 1) chk("busy_on", d_busy, 1);
            seen = d_done;
        end
        chk("done_seen", seen, 1);
        chk("done_cycle", k - 1, n + 1 + lat);
        chk("err_count", d_err, errs > maxc ? maxc : errs);
        chk("pass", d_pass, errs == 0);
        chk("first_valid", d_fev, first >= 0);
        chk("first_addr", d_fea, first >= 0 ? first : 0);
        chk("lane_mask", d_mask, mask);
        chk("rows_checked", n_rows - r0, n);
        chk("row_errs", n_rowerr - re0_, errs);
        chk("addr_count", addr_q.size() - a0, n);
        bad_addr = 0;
        for (int i = 0; i < n && a0 + i < addr_q.size(); i++)
            if (addr_q[a0+i] != (base + i) % 1024) bad_addr++;
        chk("addr_seq", bad_addr, 0);
        repeat (hold ? 12 : 3) @(negedge clk);
        chk("done_once", n_done - d0, 1);
        chk("busy_off", d_busy, 0);
        start = 0;
    endtask

    initial begin
        int errs, first;
        logic [M-1:0] mask;
        fill_same();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_busy", d_busy, 0);
            chk("rst_done", d_done, 0);
            chk("rst_pass", d_pass, 0);
            chk("rst_err", d_err, 0);
            chk("rst_rd_en", d_rd_en, 0);
            chk("rst_mask", d_mask, 0);
        end
        rstn = 1;
        @(negedge clk);

        run_sweep(0, 0, '0, 0);
        mem_r[7][5*P +: P]  = mem_r[7][5*P +: P] + 1'b1;
        mem_r[40][5*P +: P] = mem_r[40][5*P +: P] + 1'b1;
        run_sweep(0, 0, '0, 0);
        run_sweep(0, 1, 24'd1, 0);
        mem_r[40] = mem_e[40];
        mem_e[7][5*P +: P] = 24'd0;
        mem_r[7][5*P +: P] = 24'hFFFFFE;
        run_sweep(0, 1, 24'd1, 0);
        mem_e[7][5*P +: P] = 24'h800000;
        mem_r[7][5*P +: P] = 24'h7FFFFF;
        run_sweep(0, 1, 24'h100, 0);

        fill_same();
        mem_r[1022][2*P +: P] = mem_r[1022][2*P +: P] ^ 24'h10;
        mem_r[3][7*P +: P]    = mem_r[3][7*P +: P] ^ 24'h1;
        run_sweep(1, 0, '0, 0);
        for (int a = 0; a < 1024; a++) mem_r[a] = ~mem_e[a];
        run_sweep(1, 0, '0, 1);

        fill_same();
        mem_r[7][5*P +: P]  = mem_r[7][5*P +: P] + 1'b1;
        mem_r[40][5*P +: P] = mem_r[40][5*P +: P] + 1'b1;
        sel = 0;
        begin
            int d0, k;
            bit hit;
            @(negedge clk);
            d0 = n_done;
            start = 1;
            hit = 0;
            k = 0;
            while (!hit && k < 200) begin
                @(negedge clk);
                k++;
                start = 0;
                hit = d_rd_en && d_addr == 10'd30;
            end
            chk("abort_reached", hit, 1);
            abort = 1;
            @(negedge clk);
            abort = 0;
            chk("abort_busy", d_busy, 0);
            chk("abort_rd_en", d_rd_en, 0);
            repeat (80) @(negedge clk);
            chk("abort_no_done", n_done - d0, 0);
            chk("abort_err", d_err, 1);
            chk("abort_first", d_fea, 7);
            chk("abort_pass", d_pass, 0);
        end
        run_sweep(0, 0, '0, 0);

        begin
            int d0;
            d0 = n_done;
            start = 1;
            repeat (20) @(negedge clk);
            start = 0;
            rstn = 0;
            @(negedge clk);
            chk("mid_rst_busy", d_busy, 0);
            chk("mid_rst_err", d_err, 0);
            chk("mid_rst_rd_en", d_rd_en, 0);
            rstn = 1;
            repeat (80) @(negedge clk);
            chk("mid_rst_no_done", n_done - d0, 0);
        end

        for (int it = 0; it < 6; it++) begin
            fill_same();
            for (int a = 0; a < 1024; a++)
                if ($urandom % 4 == 0) begin
                    int k;
                    k = int'($urandom % M);
                    mem_r[a][k*P +: P] = mem_r[a][k*P +: P] + P'(int'($urandom % 7) - 3);
                end
            run_sweep(1'($urandom % 2), 1'($urandom % 2), P'($urandom % 4), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
